// File: rtl/product_bcd_display.sv
// Sequential double-dabble converter: binary product -> 4-digit BCD and active-low HEX3..HEX0.
// Define PRODUCT_BCD_BLANK_EN to blank leading-zero digits on HEX3..HEX1.
module product_bcd_display #(
   parameter int WIDTH = 10
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] product,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX3
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [1:0]       state;
   logic [WIDTH-1:0] bin;
   logic [15:0]      scratch;
   logic [15:0]      adj;
   logic [3:0]       cnt;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction on every digit before the shift
   always_comb begin
      adj = scratch;
      for (int unsigned i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   assign busy = (state == SHIFT);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state   <= IDLE;
         bin     <= '0;
         scratch <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         bcd     <= '0;
         HEX0    <= SEG_ZERO;
`ifdef PRODUCT_BCD_BLANK_EN
         HEX1    <= SEG_BLANK;
         HEX2    <= SEG_BLANK;
         HEX3    <= SEG_BLANK;
`else
         HEX1    <= SEG_ZERO;
         HEX2    <= SEG_ZERO;
         HEX3    <= SEG_ZERO;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin     <= product;
                  scratch <= '0;
                  cnt     <= 4'(WIDTH);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= {adj[14:0], bin[WIDTH-1]};
               bin     <= bin << 1;
               cnt     <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= DONE;
            end
            DONE: begin
               bcd  <= scratch;
               done <= 1'b1;
               HEX0 <= seg7(scratch[3:0]);
`ifdef PRODUCT_BCD_BLANK_EN
               HEX1 <= (scratch[15:4] == 12'd0) ? SEG_BLANK : seg7(scratch[7:4]);
               HEX2 <= (scratch[15:8] == 8'd0)  ? SEG_BLANK : seg7(scratch[11:8]);
               HEX3 <= (scratch[15:12] == 4'd0) ? SEG_BLANK : seg7(scratch[15:12]);
`else
               HEX1 <= seg7(scratch[7:4]);
               HEX2 <= seg7(scratch[11:8]);
               HEX3 <= seg7(scratch[15:12]);
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
